// File: rtl/serial_tx.sv
// serial_tx: framed serial transmitter.
//   A parallel word accepted over a valid/ready handshake is shifted out on
//   tx_out as: start bit (0), DATA_W data bits LSB first, optional parity bit,
//   stop bit (1). Every bit is held for CLKS_PER_BIT clocks. All outputs are
//   registered; clr is a synchronous active-high reset that aborts any frame.
// Ports:
//   clk       clock, all state updates on posedge
//   clr       synchronous active-high reset, dominates all other inputs
//   tx_data   word to send, sampled only on the accepting edge
//   tx_valid  producer has a word
//   tx_ready  transmitter can accept a word (IDLE only)
//   tx_out    serial line, idles high
//   busy      frame in progress
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              parity_q, parity_d;
  logic              tx_out_q, tx_out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bit_done;

  assign tx_out   = tx_out_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign bit_done = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Outputs are computed from the next state so that the registered line
  // changes on the same edge as the state, e.g. the start bit appears on the
  // cycle right after the accepting edge.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = div_q;
    parity_d = parity_q;
    tx_out_d = tx_out_q;
    ready_d  = ready_q;
    busy_d   = busy_q;

    if (state_q == IDLE) begin
      tx_out_d = 1'b1;
      ready_d  = 1'b1;
      busy_d   = 1'b0;
      if (tx_valid && ready_q) begin
        state_d  = START;
        shift_d  = tx_data;
        parity_d = (^tx_data) ^ (PARITY_ODD != 0);
        div_d    = '0;
        bit_d    = '0;
        tx_out_d = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b1;
      end
    end else if (!bit_done) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      case (state_q)
        START: begin
          // Present bit 0 and pre-shift so shift_q[0] is always the next bit.
          state_d  = DATA;
          tx_out_d = shift_q[0];
          shift_d  = shift_q >> 1;
          bit_d    = '0;
        end
        DATA: begin
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              tx_out_d = parity_q;
            end else begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            tx_out_d = shift_q[0];
            shift_d  = shift_q >> 1;
            bit_d    = bit_q + 1'b1;
          end
        end
        PARITY: begin
          state_d  = STOP;
          tx_out_d = 1'b1;
        end
        STOP: begin
          state_d  = IDLE;
          tx_out_d = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          tx_out_d = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

endmodule
